uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Byte queue and sequencer directly upstream of the UART transmitter.
- Accepts bytes from the debug-module side over a valid/ready write port and buffers them in a FIFO.
- Feeds the transmitter one byte at a time: one-cycle start pulse, data held stable, waits for the transmitter's done pulse.
- Decouples bursty DMI response traffic from the slow serial line.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- DONE_TIMEOUT, 200000, clock cycles to wait for TX_DONE_I before abort (only with optional feature).

Ports:
- CLK_I  input  1  system clock
- RST_NI  input  1  reset, asynchronous, active-low
- WDATA_I  input  8  byte to enqueue
- WVALID_I  input  1  WDATA_I valid
- WREADY_O  output  1  queue can accept; equals not-full (registered state)
- TX_START_O  output  1  one-cycle start pulse to transmitter
- TX_DATA_O  output  8  byte to transmitter; stable from start pulse until done
- TX_DONE_I  input  1  one-cycle pulse from transmitter, frame finished
- BUSY_O  output  1  high when FSM not IDLE or FIFO non-empty
- LEVEL_O  output  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- TIMEOUT_O  output  1  one-cycle pulse on done-timeout abort

Behaviour:
- Reset (async assert, sync release): FIFO empty, pointers 0, FSM IDLE, TX_START_O=0, TX_DATA_O=8'h00, TIMEOUT_O=0, LEVEL_O=0, WREADY_O=1, BUSY_O=0.
- Write: push when WVALID_I && WREADY_O at rising edge. WREADY_O derives from registered count only; a pop in the same cycle does not admit a write when full.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Count is tracked separately. Simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, START, WAIT_DONE.
- IDLE: if count != 0, pop the head into the TX_DATA_O register and go to START. Otherwise stay.
- START: TX_START_O=1 for exactly this cycle, then go to WAIT_DONE.
- WAIT_DONE: on TX_DONE_I go to IDLE. Otherwise stay. TX_DATA_O is unchanged throughout.
- TX_DONE_I outside WAIT_DONE (including in START) is ignored.
- Latency: byte written at edge n is visible in the FIFO at n+1. The IDLE pop occurs at edge n+1, so TX_START_O is high during cycle n+1..n+2.
- Back-to-back bytes: minimum one IDLE cycle between TX_DONE_I and the next TX_START_O.
- No bypass: even with an empty FIFO, bytes always pass through the FIFO.
- Reset mid-operation clears everything. Queued and in-flight bytes are lost, and TX_START_O drops immediately.
- Ordering strictly FIFO. No bytes are dropped except on timeout abort.

Optional Feature:
- Macro UART_TXQ_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT_DONE and clears on entry. If it reaches DONE_TIMEOUT-1 without TX_DONE_I, the FSM goes to IDLE, TIMEOUT_O pulses for one cycle, and the byte is dropped. TX_DONE_I in the same cycle as expiry counts as done, with no TIMEOUT_O.
- Undefined: no counter, TIMEOUT_O tied 0, WAIT_DONE waits indefinitely.

Decomposition:
- Shared package uart_pkg: txq_state_t enum (IDLE, START, WAIT_DONE), byte_t typedef (logic [7:0]), default DEPTH constant.
- One sub-module, uart_sync_fifo: single-clock FIFO with parameters WIDTH and DEPTH, providing push/pop/full/empty/count. It is reusable later on the RX side.

Test Plan:
- Reset, then write 8'hA5 once -> TX_START_O pulses once, TX_DATA_O=8'hA5. Hold TX_DONE_I low 50 cycles, then pulse -> BUSY_O falls the next cycle, LEVEL_O=0.
- Burst-write 16 bytes 8'h00..8'h0F with TX_DONE_I 20 cycles after each start -> WREADY_O low once LEVEL_O=16. Write 17 (8'hFF) is held off until the first pop. Output order is 00..0F then FF, each start pulse exactly 1 cycle wide.
- Full FIFO, WVALID_I=1 in the same cycle as the IDLE pop -> write not accepted that cycle, accepted the next. LEVEL_O goes 16->15->16.
- Spurious TX_DONE_I in IDLE and in START -> no state change. Byte still needs a real done in WAIT_DONE.
- Assert RST_NI low mid-WAIT_DONE with 5 bytes queued -> outputs return to reset values asynchronously. After release, no start pulse without new writes.
- With UART_TXQ_TIMEOUT_EN and DONE_TIMEOUT=100: write 8'h11 and 8'h22, never pulse done -> TIMEOUT_O pulses 100 cycles after the start pulse, then 8'h22 starts. Without the macro: no TIMEOUT_O, stuck in WAIT_DONE.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and constants for the UART transmit-side queue.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default FIFO depth of the transmit byte queue
    localparam int c_DEFAULT_DEPTH = 16;

    typedef logic [7:0] byte_t;

    // Sequencer states of the transmit queue
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } txq_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_sync_fifo
// Brief    : Single-clock FIFO with occupancy count. Push is ignored when
//            full and pop is ignored when empty, so callers may hold the
//            request lines without qualifying them. Read data is the current
//            head and is valid whenever o_empty is low.
// Revision : 1.0 - initial release
// ============================================================================
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int                  c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]       c_FULL = DEPTH[c_AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;

    logic             w_push;
    logic             w_pop;

    // Full/empty come from the registered count only, never from this
    // cycle's pop, so a pop cannot admit a push into a full FIFO.
    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rptr];

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop  && !o_empty;

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracked separately
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : uart_sync_fifo
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_queue
// Brief    : Byte queue and sequencer in front of the UART transmitter.
//            Bytes enter a FIFO over a valid/ready port; the sequencer pops
//            one byte at a time, issues a one-cycle start pulse with the
//            byte held stable, and waits for the transmitter's done pulse.
//            Optional macro UART_TXQ_TIMEOUT_EN adds a done-timeout that
//            drops the in-flight byte and pulses TIMEOUT_O.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH        = c_DEFAULT_DEPTH,
    parameter int DONE_TIMEOUT = 200000
) (
    input  logic                     CLK_I,
    input  logic                     RST_NI,
    input  logic [7:0]               WDATA_I,
    input  logic                     WVALID_I,
    output logic                     WREADY_O,
    output logic                     TX_START_O,
    output logic [7:0]               TX_DATA_O,
    input  logic                     TX_DONE_I,
    output logic                     BUSY_O,
    output logic [$clog2(DEPTH):0]   LEVEL_O,
    output logic                     TIMEOUT_O
);

    txq_state_t r_state;
    logic       r_tx_start;
    byte_t      r_tx_data;

    byte_t      w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_pop;

    // Pop only from IDLE; the FIFO ignores the request while empty
    assign w_pop = (r_state == IDLE);

    uart_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLK_I),
        .i_rst_n (RST_NI),
        .i_push  (WVALID_I),
        .i_wdata (WDATA_I),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (LEVEL_O)
    );

    assign WREADY_O   = !w_full;
    assign TX_START_O = r_tx_start;
    assign TX_DATA_O  = r_tx_data;
    assign BUSY_O     = (r_state != IDLE) || !w_empty;

`ifdef UART_TXQ_TIMEOUT_EN
    localparam int               c_TW    = $clog2(DONE_TIMEOUT);
    localparam logic [c_TW-1:0]  c_TLAST = c_TW'(DONE_TIMEOUT - 1);

    logic [c_TW-1:0] r_tcnt;
    logic            r_timeout;

    assign TIMEOUT_O = r_timeout;
`else
    logic w_unused_timeout;

    // Without the watchdog the timeout parameter has no effect
    assign w_unused_timeout = ^DONE_TIMEOUT;
    assign TIMEOUT_O        = 1'b0;
`endif

    // Sequencer: pop head into the output register, pulse start, wait done
    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            r_state    <= IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
`ifdef UART_TXQ_TIMEOUT_EN
            r_tcnt     <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
`ifdef UART_TXQ_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_tx_data  <= w_head;
                        r_tx_start <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    // A done pulse here is ignored: the frame has not begun
                    r_tx_start <= 1'b0;
                    r_state    <= WAIT_DONE;
`ifdef UART_TXQ_TIMEOUT_EN
                    r_tcnt     <= '0;
`endif
                end
                WAIT_DONE: begin
                    if (TX_DONE_I) begin
                        r_state <= IDLE;
`ifdef UART_TXQ_TIMEOUT_EN
                    end else if (r_tcnt == c_TLAST) begin
                        // Transmitter never answered: drop the byte
                        r_state   <= IDLE;
                        r_timeout <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
`endif
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_tx_start <= 1'b0;
                end
            endcase
        end
    end

endmodule : uart_tx_queue
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_queue
// Brief    : Directed self-checking bench for uart_tx_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

    logic       clk;
    logic       rst_n;
    logic [7:0] wdata;
    logic       wvalid;
    logic       wready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       busy;
    logic [4:0] level;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_b [18];

    uart_tx_queue #(
        .DEPTH        (16),
        .DONE_TIMEOUT (100)
    ) dut (
        .CLK_I      (clk),
        .RST_NI     (rst_n),
        .WDATA_I    (wdata),
        .WVALID_I   (wvalid),
        .WREADY_O   (wready),
        .TX_START_O (tx_start),
        .TX_DATA_O  (tx_data),
        .TX_DONE_I  (tx_done),
        .BUSY_O     (busy),
        .LEVEL_O    (level),
        .TIMEOUT_O  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int n;
        int starts;

        for (int i = 0; i < 16; i++) exp_b[i] = 8'(i);
        exp_b[16] = 8'hFF;
        exp_b[17] = 8'hEE;

        rst_n   = 1'b0;
        wdata   = 8'h00;
        wvalid  = 1'b0;
        tx_done = 1'b0;
        tick();
        tick();
        chk("rst_wready",  wready,   1);
        chk("rst_start",   tx_start, 0);
        chk("rst_data",    tx_data,  8'h00);
        chk("rst_busy",    busy,     0);
        chk("rst_level",   level,    0);
        chk("rst_timeout", timeout,  0);
        rst_n = 1'b1;
        tick();

        // ---- single byte, long wait for done ----
        wdata = 8'hA5; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk("a5_level1", level, 1);
        chk("a5_nostart", tx_start, 0);
        chk("a5_busy", busy, 1);
        tick();
        chk("a5_start", tx_start, 1);
        chk("a5_data", tx_data, 8'hA5);
        chk("a5_level0", level, 0);
        starts = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx_start) starts++;
        end
        chk("a5_one_pulse", starts, 0);
        chk("a5_wait_busy", busy, 1);
        chk("a5_data_hold", tx_data, 8'hA5);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("a5_busy_fall", busy, 0);
        chk("a5_level_end", level, 0);

        // ---- burst of 17 bytes, fill to full ----
        for (int i = 0; i < 17; i++) begin
            wdata = exp_b[i]; wvalid = 1'b1;
            tick();
            if (i == 1) begin
                chk("burst_start0", tx_start, 1);
                chk("burst_data0", tx_data, 8'h00);
            end
            if (i == 2) chk("burst_width0", tx_start, 0);
        end
        chk("burst_full_level", level, 16);
        chk("burst_full_wready", wready, 0);

        // ---- held write while full, same-cycle pop does not admit it ----
        wdata = 8'hEE; wvalid = 1'b1;
        tick();
        chk("hold_level", level, 16);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("hold_level_done", level, 16);
        chk("hold_gap", tx_start, 0);
        tick();
        chk("pop_level15", level, 15);
        chk("pop_start1", tx_start, 1);
        chk("pop_data1", tx_data, 8'h01);
        chk("pop_wready", wready, 1);
        tick();
        chk("refill_level16", level, 16);
        chk("refill_wready", wready, 0);
        chk("width1", tx_start, 0);
        wvalid = 1'b0;

        for (int k = 1; k <= 17; k++) begin
            repeat (17) tick();
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
            chk("order_gap", tx_start, 0);
            if (k < 17) begin
                tick();
                chk("order_start", tx_start, 1);
                chk("order_data", tx_data, exp_b[k+1]);
                tick();
                chk("order_width", tx_start, 0);
            end
        end
        chk("burst_end_busy", busy, 0);
        chk("burst_end_level", level, 0);

        // ---- spurious done in IDLE and START ----
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("spur_idle_busy", busy, 0);
        chk("spur_idle_start", tx_start, 0);
        wdata = 8'h33; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tx_done = 1'b1;
        tick();
        chk("spur_start", tx_start, 1);
        chk("spur_data", tx_data, 8'h33);
        tick();
        tx_done = 1'b0;
        chk("spur_start_ignored", busy, 1);
        chk("spur_width", tx_start, 0);
        repeat (5) tick();
        chk("spur_still_wait", busy, 1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("spur_real_done", busy, 0);

        // ---- reset mid WAIT_DONE with 5 queued bytes ----
        wdata = 8'h44; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        chk("rs_start", tx_start, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            wdata = 8'h50 + 8'(i); wvalid = 1'b1;
            tick();
        end
        wvalid = 1'b0;
        chk("rs_level5", level, 5);
        chk("rs_data44", tx_data, 8'h44);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_async_level", level, 0);
        chk("rs_async_busy", busy, 0);
        chk("rs_async_data", tx_data, 8'h00);
        chk("rs_async_wready", wready, 1);
        chk("rs_async_start", tx_start, 0);
        tick();
        rst_n = 1'b1;
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_start) starts++;
        end
        chk("rs_no_start", starts, 0);
        chk("rs_level_after", level, 0);

`ifdef UART_TXQ_TIMEOUT_EN
        // ---- done timeout drops the byte and moves on ----
        wdata = 8'h11; wvalid = 1'b1;
        tick();
        wdata = 8'h22;
        tick();
        wvalid = 1'b0;
        chk("to_start11", tx_start, 1);
        chk("to_data11", tx_data, 8'h11);
        n = 0;
        while (n < 300 && !timeout) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 101);
        tick();
        chk("to_pulse_width", timeout, 0);
        chk("to_start22", tx_start, 1);
        chk("to_data22", tx_data, 8'h22);
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("to_done_busy", busy, 0);
        chk("to_done_notimeout", timeout, 0);
`else
        // ---- no watchdog: waits indefinitely ----
        wdata = 8'h11; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        tick();
        chk("nto_start", tx_start, 1);
        n = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (timeout) n++;
        end
        chk("nto_no_timeout", n, 0);
        chk("nto_stuck_busy", busy, 1);
        chk("nto_data", tx_data, 8'h11);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("nto_done_busy", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_tx_queue
`default_nettype wire
